// File: rtl/mkio_bc_control.sv
// rtl/mkio_bc_control.sv - MKIO bus-controller message sequencer
// One message per start: command word out, then data out + status in, or status + data in.
module mkio_bc_control #(
   parameter logic [15:0] RESP_TIMEOUT = 16'd400,
   parameter logic [15:0] TX_TIMEOUT   = 16'd64
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [4:0]  rt_addr_i,
   input  logic        tr_i,
   input  logic [4:0]  subaddr_i,
   input  logic [4:0]  word_cnt_i,
   input  logic        buf_we_i,
   input  logic [4:0]  buf_addr_i,
   input  logic [15:0] buf_wdata_i,
   output logic [15:0] buf_rdata_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [15:0] status_word_o,
   output logic        err_timeout_o,
   output logic        err_parity_o,
   output logic        err_addr_o,
   output logic        err_sync_o,
   output logic        tx_ready_o,
   output logic [15:0] tx_data_o,
   output logic        tx_cd_o,
   input  logic        tx_busy_i,
   input  logic        rx_done_i,
   input  logic [15:0] rx_data_i,
   input  logic        rx_cd_i,
   input  logic        p_error_i
);

   typedef enum logic [2:0] {
      S_IDLE, S_TX_CMD, S_TX_DATA, S_WAIT_STAT, S_RX_DATA, S_DONE
   } state_e;

   typedef enum logic [1:0] {PH_STROBE, PH_RISE, PH_FALL} phase_e;

   state_e      state_q;
   phase_e      phase_q;
   logic [4:0]  rt_q, sa_q, cnt_q, idx_q;
   logic        tr_q;
   logic [15:0] tcnt_q;
   logic        busy_q, done_q, tx_ready_q, tx_cd_q;
   logic [15:0] tx_data_q, status_q, buf_rdata_q;
   logic        err_timeout_q, err_parity_q, err_addr_q, err_sync_q;
   logic [15:0] mem_q [32];

   logic [4:0]  last_idx;
   logic        rx_store, host_we;
   logic [15:0] tx_word_d;

   // cnt_q==0 means 32 words, so the last index wraps naturally to 31
   assign last_idx = cnt_q - 5'd1;
   assign rx_store = (state_q == S_RX_DATA) && rx_done_i && rx_cd_i;
   assign host_we  = buf_we_i && !busy_q;

   always_comb begin
      tx_word_d = mem_q[idx_q];
      if (state_q == S_TX_CMD) tx_word_d = {rt_q, tr_q, sa_q, cnt_q};
   end

   always_ff @(posedge clk_i) begin
      if (rx_store)     mem_q[idx_q] <= rx_data_i;
      else if (host_we) mem_q[buf_addr_i] <= buf_wdata_i;
      buf_rdata_q <= mem_q[buf_addr_i];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= S_IDLE;
         phase_q       <= PH_STROBE;
         rt_q          <= '0;
         tr_q          <= 1'b0;
         sa_q          <= '0;
         cnt_q         <= '0;
         idx_q         <= '0;
         tcnt_q        <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         tx_ready_q    <= 1'b0;
         tx_cd_q       <= 1'b0;
         tx_data_q     <= '0;
         status_q      <= '0;
         err_timeout_q <= 1'b0;
         err_parity_q  <= 1'b0;
         err_addr_q    <= 1'b0;
         err_sync_q    <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         tx_ready_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  rt_q          <= rt_addr_i;
                  tr_q          <= tr_i;
                  sa_q          <= subaddr_i;
                  cnt_q         <= word_cnt_i;
                  idx_q         <= '0;
                  status_q      <= '0;
                  err_timeout_q <= 1'b0;
                  err_parity_q  <= 1'b0;
                  err_addr_q    <= 1'b0;
                  err_sync_q    <= 1'b0;
                  phase_q       <= PH_STROBE;
                  busy_q        <= 1'b1;
                  state_q       <= S_TX_CMD;
               end
            end
            S_TX_CMD, S_TX_DATA: begin
               case (phase_q)
                  PH_STROBE: begin
                     tx_ready_q <= 1'b1;
                     tx_data_q  <= tx_word_d;
                     tx_cd_q    <= (state_q == S_TX_DATA);
                     tcnt_q     <= '0;
                     phase_q    <= PH_RISE;
                  end
                  PH_RISE: begin
                     if (tx_busy_i) begin
                        phase_q <= PH_FALL;
                     end else if (tcnt_q == TX_TIMEOUT - 16'd1) begin
                        err_timeout_q <= 1'b1;
                        busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_DONE;
                     end else begin
                        tcnt_q <= tcnt_q + 16'd1;
                     end
                  end
                  default: begin
                     if (!tx_busy_i) begin
                        phase_q <= PH_STROBE;
                        tcnt_q  <= '0;
                        if (state_q == S_TX_CMD) begin
                           state_q <= tr_q ? S_WAIT_STAT : S_TX_DATA;
                        end else if (idx_q == last_idx) begin
                           idx_q   <= '0;
                           state_q <= S_WAIT_STAT;
                        end else begin
                           idx_q <= idx_q + 5'd1;
                        end
                     end
                  end
               endcase
            end
            S_WAIT_STAT: begin
               if (rx_done_i) begin
                  status_q <= rx_data_i;
                  tcnt_q   <= '0;
                  if (p_error_i) begin
                     err_parity_q <= 1'b1;
                     busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_DONE;
                  end else if (rx_cd_i) begin
                     err_sync_q <= 1'b1;
                     busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_DONE;
                  end else if (rx_data_i[15:11] != rt_q) begin
                     err_addr_q <= 1'b1;
                     busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_DONE;
                  end else if (tr_q) begin
                     state_q <= S_RX_DATA;
                  end else begin
                     busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_DONE;
                  end
               end else if (tcnt_q == RESP_TIMEOUT - 16'd1) begin
                  err_timeout_q <= 1'b1;
                  busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_DONE;
               end else begin
                  tcnt_q <= tcnt_q + 16'd1;
               end
            end
            S_RX_DATA: begin
               if (rx_done_i) begin
                  tcnt_q <= '0;
                  if (!rx_cd_i) begin
                     err_sync_q <= 1'b1;
                     busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_DONE;
                  end else if (p_error_i) begin
                     err_parity_q <= 1'b1;
                     busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_DONE;
                  end else if (idx_q == last_idx) begin
                     idx_q  <= '0;
                     busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_DONE;
                  end else begin
                     idx_q <= idx_q + 5'd1;
                  end
               end else if (tcnt_q == RESP_TIMEOUT - 16'd1) begin
                  err_timeout_q <= 1'b1;
                  busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_DONE;
               end else begin
                  tcnt_q <= tcnt_q + 16'd1;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign buf_rdata_o   = buf_rdata_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign status_word_o = status_q;
   assign err_timeout_o = err_timeout_q;
   assign err_parity_o  = err_parity_q;
   assign err_addr_o    = err_addr_q;
   assign err_sync_o    = err_sync_q;
   assign tx_ready_o    = tx_ready_q;
   assign tx_data_o     = tx_data_q;
   assign tx_cd_o       = tx_cd_q;

endmodule

// File: tb/tb_mkio_bc_control.sv
// tb/tb_mkio_bc_control.sv - self-checking bench for mkio_bc_control
// Message-level model predicts tx words, buffer image and final flags for each message.
module tb_mkio_bc_control;

   localparam logic [15:0] RESP_TIMEOUT = 16'd400;
   localparam logic [15:0] TX_TIMEOUT   = 16'd64;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic [4:0]  rt_addr_i = '0;
   logic        tr_i = 1'b0;
   logic [4:0]  subaddr_i = '0;
   logic [4:0]  word_cnt_i = '0;
   logic        buf_we_i = 1'b0;
   logic [4:0]  buf_addr_i = '0;
   logic [15:0] buf_wdata_i = '0;
   logic [15:0] buf_rdata_o;
   logic        busy_o, done_o;
   logic [15:0] status_word_o;
   logic        err_timeout_o, err_parity_o, err_addr_o, err_sync_o;
   logic        tx_ready_o;
   logic [15:0] tx_data_o;
   logic        tx_cd_o;
   logic        tx_busy_i = 1'b0;
   logic        rx_done_i = 1'b0;
   logic [15:0] rx_data_i = '0;
   logic        rx_cd_i = 1'b0;
   logic        p_error_i = 1'b0;

   mkio_bc_control #(.RESP_TIMEOUT(RESP_TIMEOUT), .TX_TIMEOUT(TX_TIMEOUT)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .rt_addr_i(rt_addr_i),
      .tr_i(tr_i), .subaddr_i(subaddr_i), .word_cnt_i(word_cnt_i),
      .buf_we_i(buf_we_i), .buf_addr_i(buf_addr_i), .buf_wdata_i(buf_wdata_i),
      .buf_rdata_o(buf_rdata_o), .busy_o(busy_o), .done_o(done_o),
      .status_word_o(status_word_o), .err_timeout_o(err_timeout_o),
      .err_parity_o(err_parity_o), .err_addr_o(err_addr_o), .err_sync_o(err_sync_o),
      .tx_ready_o(tx_ready_o), .tx_data_o(tx_data_o), .tx_cd_o(tx_cd_o),
      .tx_busy_i(tx_busy_i), .rx_done_i(rx_done_i), .rx_data_i(rx_data_i),
      .rx_cd_i(rx_cd_i), .p_error_i(p_error_i)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   logic [15:0] mbuf [32];
   logic [16:0] exp_tx [$];
   logic [15:0] rxw [$];
   logic        rxc [$];
   logic        rxp [$];
   int          tx_done_cnt = 0;
   int          drop_cyc = 0;
   int          done_cyc = 0;
   int          done_cnt = 0;
   logic [15:0] last_cmd = '0;
   logic [15:0] held = '0;
   bit          tx_en = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Transmitter stand-in: busy rises two cycles after a strobe, lasts four cycles.
   initial begin
      forever begin
         @(negedge clk_i);
         if (rst_ni && tx_ready_o && tx_en) begin
            repeat (2) @(negedge clk_i);
            tx_busy_i = 1'b1;
            repeat (4) @(negedge clk_i);
            tx_busy_i = 1'b0;
            drop_cyc = cyc;
            tx_done_cnt++;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk_i);
         if (rst_ni) begin
            chk("done_busy_excl", {31'd0, done_o & busy_o}, 32'd0);
            if (tx_ready_o) begin
               if (exp_tx.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL tx_unexpected: got %h cd %0d expected no word", tx_data_o, tx_cd_o);
               end else begin
                  chk("tx_word", {15'd0, tx_cd_o, tx_data_o}, {15'd0, exp_tx.pop_front()});
               end
               if (!tx_cd_o) last_cmd = tx_data_o;
               held = tx_data_o;
            end
            if (tx_busy_i) chk("tx_hold", {16'd0, tx_data_o}, {16'd0, held});
            if (done_o) begin
               done_cnt++;
               done_cyc = cyc;
            end
         end
      end
   end

   task automatic host_wr(input logic [4:0] a, input logic [15:0] d);
      @(negedge clk_i);
      buf_we_i = 1'b1; buf_addr_i = a; buf_wdata_i = d;
      @(negedge clk_i);
      buf_we_i = 1'b0;
      mbuf[a] = d;
   endtask

   task automatic rd(input logic [4:0] a, output logic [15:0] v);
      @(negedge clk_i);
      buf_addr_i = a;
      @(negedge clk_i);
      v = buf_rdata_o;
   endtask

   task automatic check_buf(input string name);
      logic [15:0] v;
      for (int a = 0; a < 32; a++) begin
         rd(a[4:0], v);
         chk(name, {16'd0, v}, {16'd0, mbuf[a]});
      end
   endtask

   task automatic add_rx(input logic [15:0] d, input logic c, input logic p);
      rxw.push_back(d); rxc.push_back(c); rxp.push_back(p);
   endtask

   task automatic clr_rx();
      rxw.delete(); rxc.delete(); rxp.delete();
   endtask

   task automatic send_rx(input logic [15:0] d, input logic cd, input logic pe);
      repeat (3) @(negedge clk_i);
      rx_data_i = d; rx_cd_i = cd; p_error_i = pe; rx_done_i = 1'b1;
      @(negedge clk_i);
      rx_done_i = 1'b0; p_error_i = 1'b0; rx_cd_i = 1'b0;
   endtask

   // Predict the outcome, drive the message, then compare flags, status and buffer.
   task automatic run_msg(input logic [4:0] rt, input logic tr, input logic [4:0] sa,
                          input logic [4:0] cnt, input bit poke);
      int n, n_tx, used, t, base_tx, base_done;
      bit e_to, e_par, e_addr, e_sync;
      logic [15:0] e_stat, s;
      n = (cnt == 0) ? 32 : int'(cnt);
      e_to = 0; e_par = 0; e_addr = 0; e_sync = 0; e_stat = '0; used = 0; n_tx = 0;
      exp_tx.push_back({1'b0, rt, tr, sa, cnt});
      if (!tx_en) begin
         e_to = 1;
      end else begin
         if (!tr) for (int i = 0; i < n; i++) exp_tx.push_back({1'b1, mbuf[i]});
         n_tx = tr ? 1 : 1 + n;
         if (rxw.size() == 0) begin
            e_to = 1;
         end else begin
            s = rxw[0];
            e_stat = s;
            used = 1;
            if (rxp[0]) e_par = 1;
            else if (rxc[0]) e_sync = 1;
            else if (s[15:11] != rt) e_addr = 1;
            else if (tr) begin
               for (int i = 0; i < n; i++) begin
                  if (used >= rxw.size()) begin e_to = 1; break; end
                  used++;
                  if (!rxc[used-1]) begin e_sync = 1; break; end
                  mbuf[i] = rxw[used-1];
                  if (rxp[used-1]) begin e_par = 1; break; end
               end
            end
         end
      end

      base_tx = tx_done_cnt;
      base_done = done_cnt;
      @(negedge clk_i);
      rt_addr_i = rt; tr_i = tr; subaddr_i = sa; word_cnt_i = cnt; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      chk("busy_after_start", {31'd0, busy_o}, 32'd1);
      if (poke) begin
         @(negedge clk_i);
         start_i = 1'b1; rt_addr_i = 5'd31; tr_i = ~tr;
         buf_we_i = 1'b1; buf_addr_i = 5'd31; buf_wdata_i = 16'hDEAD;
         @(negedge clk_i);
         start_i = 1'b0; buf_we_i = 1'b0;
      end
      t = 0;
      while (tx_done_cnt < base_tx + n_tx && t < 5000) begin
         @(negedge clk_i);
         t++;
      end
      if (t >= 5000) chk("tx_wait_bound", t, 0);
      for (int i = 0; i < used; i++) send_rx(rxw[i], rxc[i], rxp[i]);
      t = 0;
      while (!done_o && t < 3000) begin
         @(negedge clk_i);
         t++;
      end
      if (t >= 3000) chk("done_wait_bound", t, 0);
      if (poke) begin
         start_i = 1'b1;
         @(negedge clk_i);
         start_i = 1'b0;
      end
      repeat (2) @(negedge clk_i);
      chk("busy_idle", {31'd0, busy_o}, 32'd0);
      chk("done_pulses", done_cnt - base_done, 1);
      chk("err_timeout", {31'd0, err_timeout_o}, {31'd0, e_to});
      chk("err_parity", {31'd0, err_parity_o}, {31'd0, e_par});
      chk("err_addr", {31'd0, err_addr_o}, {31'd0, e_addr});
      chk("err_sync", {31'd0, err_sync_o}, {31'd0, e_sync});
      chk("status_word", {16'd0, status_word_o}, {16'd0, e_stat});
      if (tx_en && rxw.size() == 0)
         chk("resp_timeout_cycles", done_cyc - (drop_cyc + 1), int'(RESP_TIMEOUT));
      check_buf("buf_image");
   endtask

   initial begin
      logic [15:0] v;
      int t, base_tx, base_done;
      repeat (2) @(negedge clk_i);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_tx_ready", {31'd0, tx_ready_o}, 32'd0);
      chk("rst_tx_cd", {31'd0, tx_cd_o}, 32'd0);
      chk("rst_tx_data", {16'd0, tx_data_o}, 32'd0);
      chk("rst_status", {16'd0, status_word_o}, 32'd0);
      chk("rst_errs", {28'd0, err_timeout_o, err_parity_o, err_addr_o, err_sync_o}, 32'd0);
      rst_ni = 1'b1;

      for (int a = 0; a < 32; a++) host_wr(a[4:0], 16'h0100 + 16'(a));
      host_wr(5'd0, 16'h1111);
      host_wr(5'd1, 16'h2222);
      host_wr(5'd2, 16'h3333);
      check_buf("buf_init");

      clr_rx(); add_rx(16'h0800, 1'b0, 1'b0);
      run_msg(5'd1, 1'b0, 5'd5, 5'd3, 1'b1);
      chk("cmd_bc_rt", {16'd0, last_cmd}, 32'h08A3);
      chk("status_bc_rt", {16'd0, status_word_o}, 32'h0800);

      clr_rx(); add_rx(16'h0800, 1'b0, 1'b0); add_rx(16'h1234, 1'b1, 1'b0); add_rx(16'hABCD, 1'b1, 1'b0);
      run_msg(5'd1, 1'b1, 5'd3, 5'd2, 1'b0);
      chk("cmd_rt_bc", {16'd0, last_cmd}, 32'h0C62);
      rd(5'd0, v); chk("rt_bc_buf0", {16'd0, v}, 32'h1234);
      rd(5'd1, v); chk("rt_bc_buf1", {16'd0, v}, 32'hABCD);

      clr_rx(); add_rx(16'h1800, 1'b0, 1'b0);
      for (int i = 0; i < 32; i++) add_rx(16'(i), 1'b1, 1'b0);
      run_msg(5'd3, 1'b1, 5'd7, 5'd0, 1'b0);
      rd(5'd31, v); chk("cnt32_buf31", {16'd0, v}, 32'd31);

      clr_rx();
      run_msg(5'd2, 1'b1, 5'd1, 5'd1, 1'b0);
      chk("no_reply_timeout", {31'd0, err_timeout_o}, 32'd1);

      clr_rx(); add_rx(16'h1000, 1'b0, 1'b0);
      run_msg(5'd1, 1'b1, 5'd2, 5'd2, 1'b0);
      chk("addr_err_lit", {31'd0, err_addr_o}, 32'd1);

      clr_rx(); add_rx(16'h0800, 1'b0, 1'b0); add_rx(16'hAAAA, 1'b1, 1'b0); add_rx(16'hBBBB, 1'b1, 1'b1);
      run_msg(5'd1, 1'b1, 5'd4, 5'd4, 1'b0);
      rd(5'd1, v); chk("parity_buf1", {16'd0, v}, 32'hBBBB);

      clr_rx(); add_rx(16'h0800, 1'b0, 1'b0); add_rx(16'h5555, 1'b0, 1'b0);
      run_msg(5'd1, 1'b1, 5'd6, 5'd2, 1'b0);

      // Abort a BC->RT message with reset while a data-word strobe is on the wire.
      base_tx = tx_done_cnt;
      base_done = done_cnt;
      exp_tx.push_back({1'b0, 5'd4, 1'b0, 5'd2, 5'd3});
      for (int i = 0; i < 3; i++) exp_tx.push_back({1'b1, mbuf[i]});
      @(negedge clk_i);
      rt_addr_i = 5'd4; tr_i = 1'b0; subaddr_i = 5'd2; word_cnt_i = 5'd3; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      t = 0;
      while (tx_done_cnt < base_tx + 2 && t < 500) begin @(negedge clk_i); t++; end
      while (!tx_ready_o && t < 600) begin @(negedge clk_i); t++; end
      if (t >= 500) chk("abort_wait_bound", t, 0);
      rst_ni = 1'b0;
      #1;
      chk("abort_tx_ready", {31'd0, tx_ready_o}, 32'd0);
      chk("abort_busy", {31'd0, busy_o}, 32'd0);
      chk("abort_done", {31'd0, done_o}, 32'd0);
      exp_tx.delete();
      repeat (12) @(negedge clk_i);
      chk("abort_no_done", done_cnt - base_done, 0);
      rst_ni = 1'b1;
      clr_rx(); add_rx(16'h2000, 1'b0, 1'b0);
      run_msg(5'd4, 1'b0, 5'd2, 5'd3, 1'b0);

      tx_en = 1'b0;
      clr_rx();
      run_msg(5'd1, 1'b0, 5'd1, 5'd1, 1'b0);
      tx_en = 1'b1;

      chk("tx_queue_empty", exp_tx.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
